// File: rtl/kyber_mul_iter.sv
// Iterative shift-add multiplier feeding the Kyber modular reduction stage.
// Define KYBER_MUL_RADIX4_EN to retire two multiplier bits per RUN cycle.
module kyber_mul_iter #(
    parameter int OPW = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [OPW-1:0]   a_i,
    input  logic [OPW-1:0]   b_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [2*OPW-1:0] product_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);
    localparam int PW = 2 * OPW;
`ifdef KYBER_MUL_RADIX4_EN
    localparam int STEPS = OPW / 2;
`else
    localparam int STEPS = OPW;
`endif
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [OPW-1:0]  r_mplier;
    logic [CW-1:0]   r_count;

    logic            w_in_hs;
    logic            w_last;
    logic [PW-1:0]   w_addend;
    logic [PW-1:0]   w_mcand_nxt;
    logic [OPW-1:0]  w_mplier_nxt;

    assign in_ready_o  = (r_state == IDLE) || ((r_state == DONE) && out_ready_i);
    assign w_in_hs     = in_valid_i && in_ready_o;
    assign w_last      = (r_count == CW'(STEPS - 1));
    assign out_valid_o = (r_state == DONE);
    assign busy_o      = (r_state == RUN);
    assign product_o   = r_acc;

`ifdef KYBER_MUL_RADIX4_EN
    // Radix-4 partial product: 0, 1x, 2x or 3x the shifted multiplicand.
    always_comb begin
        w_addend = '0;
        case (r_mplier[1:0])
            2'd1:    w_addend = r_mcand;
            2'd2:    w_addend = r_mcand << 1;
            2'd3:    w_addend = r_mcand + (r_mcand << 1);
            default: w_addend = '0;
        endcase
    end
    assign w_mcand_nxt  = r_mcand << 2;
    assign w_mplier_nxt = r_mplier >> 2;
`else
    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign w_mcand_nxt  = r_mcand << 1;
    assign w_mplier_nxt = r_mplier >> 1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid_i) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready_i) w_state_nxt = in_valid_i ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // A load in DONE overrides the held result on the same edge it is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_in_hs) begin
            r_acc    <= '0;
            r_mcand  <= PW'(a_i);
            r_mplier <= b_i;
            r_count  <= '0;
        end else if (r_state == RUN) begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_count  <= r_count + CW'(1);
        end
    end
endmodule

// File: tb/tb_kyber_mul_iter.sv
// Scoreboard bench for kyber_mul_iter: expected products and accept edges are
// queued at the input handshake and checked when the result is consumed.
module tb_kyber_mul_iter;
    localparam int OPW = 12;
`ifdef KYBER_MUL_RADIX4_EN
    localparam int STEPS = OPW / 2;
`else
    localparam int STEPS = OPW;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [OPW-1:0]   a = '0, b = '0;
    logic             in_valid = 1'b0, out_ready = 1'b0;
    logic             in_ready, out_valid, busy;
    logic [2*OPW-1:0] product;

    kyber_mul_iter #(.OPW(OPW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .product_o(product), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [2*OPW-1:0] exp_q[$];
    int acc_q[$];
    logic prev_vld = 1'b0;
    bit tp_mode = 1'b0;
    int last_rise = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency on each out_valid rise, product on each output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_vld) begin
                if (acc_q.size() == 0) chk("unexp_valid", 64'(out_valid), 64'd0);
                else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(STEPS));
                if (tp_mode && last_rise >= 0) chk("period", 64'(cyc - last_rise), 64'(STEPS + 1));
                last_rise = cyc;
            end
            if (busy) chk("busy_vs_valid", 64'(out_valid), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexp_product", 64'(product), 64'hdead);
                else chk("product", 64'(product), 64'(exp_q.pop_front()));
            end
            prev_vld = out_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    // Returns at posedge+1 right after the input handshake edge.
    task automatic send(input logic [OPW-1:0] xa, input logic [OPW-1:0] xb, input bit keep);
        int n;
        a = xa; b = xb; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 64'(in_ready), 64'd1);
        exp_q.push_back((2*OPW)'(xa) * (2*OPW)'(xb));
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [OPW-1:0] ra, rb;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        send(12'd3328, 12'd3328, 1'b0); drain();
        send(12'd4095, 12'd4095, 1'b0); drain();
        send(12'd0, 12'd4095, 1'b0); drain();
        send(12'd1, 12'd1, 1'b0); drain();
        for (int i = 0; i < 3; i++) begin
            ra = OPW'($urandom); rb = OPW'($urandom);
            send(ra, rb, 1'b0); drain();
        end

        // Downstream stall: result must be held and input blocked.
        out_ready = 1'b0;
        send(12'd3329, 12'd17, 1'b0);
        for (int i = 0; i < STEPS; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_product", 64'(product), 64'd56593);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back: both sides always ready.
        tp_mode = 1'b1; last_rise = -1;
        send(12'd11, 12'd13, 1'b1);
        send(12'd4095, 12'd2, 1'b1);
        send(12'd3328, 12'd7, 1'b1);
        send(12'd1000, 12'd999, 1'b0);
        drain();
        tp_mode = 1'b0;

        // Reset mid-run discards the operation.
        send(12'd100, 12'd200, 1'b0);
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete(); acc_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < STEPS + 4; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(12'd2, 12'd3, 1'b0); drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
